// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store sequencer; misaligned halfword/word accesses become byte beats
// Only WORD_WIDTH=32 is meaningful; byte lanes and extension are hard-wired for a 32-bit word.
`timescale 1ns/1ps
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module load_store_unit #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int WORD_WIDTH = `WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqWrite,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] reqAddr,
  input  logic [WORD_WIDTH-1:0] reqData,
  output logic                  respValid,
  output logic [WORD_WIDTH-1:0] respData,
  output logic                  respErr,
  output logic                  memRead,
  output logic                  memWrite,
  output logic [1:0]            addrUnit,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [WORD_WIDTH-1:0] memDataIn,
  input  logic [WORD_WIDTH-1:0] memDataOut
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CAPTURE, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t      state;
  logic        op_write;
  logic        op_err;
  logic        op_split;
  logic [2:0]  op_f3;
  logic [1:0]  beat;
  logic [1:0]  last_beat;
  logic [31:0] st_data;
  logic [31:0] asm_data;

  logic [1:0]  req_size;
  logic        req_legal;
  logic        req_split;
  logic [1:0]  req_last;
  logic [1:0]  next_beat;
  logic [31:0] resp_ext;

  always_comb begin
    req_size  = funct3[1:0];
    req_legal = reqWrite ? (!funct3[2] && (funct3[1:0] != 2'b11))
                         : ((funct3[1:0] != 2'b11) && !(funct3[2] && funct3[1]));
    req_split = ((req_size == 2'b01) && reqAddr[0]) ||
                ((req_size == 2'b10) && (reqAddr[1:0] != 2'b00));
    req_last  = !req_split ? 2'd0 : ((req_size == 2'b01) ? 2'd1 : 2'd3);
    next_beat = beat + 2'd1;
  end

  assign reqReady  = (state == S_IDLE);
  assign respValid = (state == S_DONE);
  assign respErr   = (state == S_DONE) && op_err;
  assign memRead   = (state == S_ACCESS) && !op_write;
  assign memWrite  = (state == S_ACCESS) && op_write;

  always_comb begin
    resp_ext = asm_data;
    case (op_f3)
      3'b000:  resp_ext = {{24{asm_data[7]}}, asm_data[7:0]};
      3'b001:  resp_ext = {{16{asm_data[15]}}, asm_data[15:0]};
      3'b100:  resp_ext = {24'd0, asm_data[7:0]};
      3'b101:  resp_ext = {16'd0, asm_data[15:0]};
      default: resp_ext = asm_data;
    endcase
    respData = (state == S_DONE && !op_write && !op_err) ? resp_ext : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_write  <= 1'b0;
      op_err    <= 1'b0;
      op_split  <= 1'b0;
      op_f3     <= 3'd0;
      beat      <= 2'd0;
      last_beat <= 2'd0;
      st_data   <= '0;
      asm_data  <= '0;
      addrUnit  <= 2'b00;
      memAddr   <= '0;
      memDataIn <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (reqValid) begin
            op_write  <= reqWrite;
            op_f3     <= funct3;
            op_err    <= !req_legal;
            op_split  <= req_split;
            beat      <= 2'd0;
            last_beat <= req_last;
            st_data   <= reqData;
            asm_data  <= '0;
            if (!req_legal) begin
              state <= S_DONE;
            end else begin
              state     <= S_ACCESS;
              memAddr   <= reqAddr;
              addrUnit  <= req_split ? 2'b00 : req_size;
              memDataIn <= !reqWrite ? '0 :
                           (req_split ? {24'd0, reqData[7:0]} : reqData);
            end
          end
        end
        S_ACCESS: begin
          if (!op_write) begin
            state <= S_CAPTURE;
          end else if (beat == last_beat) begin
            state <= S_DONE;
          end else begin
            beat      <= next_beat;
            memAddr   <= memAddr + ADDR_ONE;
            memDataIn <= {24'd0, st_data[{next_beat, 3'b000} +: 8]};
          end
        end
        S_CAPTURE: begin
          // Split loads assemble one byte lane per beat; aligned loads take the native width.
          if (op_split) begin
            asm_data[{beat, 3'b000} +: 8] <= memDataOut[7:0];
          end else begin
            case (addrUnit)
              2'b00:   asm_data <= {24'd0, memDataOut[7:0]};
              2'b01:   asm_data <= {16'd0, memDataOut[15:0]};
              default: asm_data <= memDataOut;
            endcase
          end
          if (beat == last_beat) begin
            state <= S_DONE;
          end else begin
            beat    <= next_beat;
            memAddr <= memAddr + ADDR_ONE;
            state   <= S_ACCESS;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a byte-array memory model
`timescale 1ns/1ps
module tb_load_store_unit;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          reqValid = 1'b0;
  logic          reqReady;
  logic          reqWrite = 1'b0;
  logic [2:0]    funct3 = 3'd0;
  logic [AW-1:0] reqAddr = '0;
  logic [31:0]   reqData = '0;
  logic          respValid;
  logic [31:0]   respData;
  logic          respErr;
  logic          memRead;
  logic          memWrite;
  logic [1:0]    addrUnit;
  logic [AW-1:0] memAddr;
  logic [31:0]   memDataIn;
  logic [31:0]   memDataOut = '0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(AW), .WORD_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite), .funct3(funct3),
    .reqAddr(reqAddr), .reqData(reqData),
    .respValid(respValid), .respData(respData), .respErr(respErr),
    .memRead(memRead), .memWrite(memWrite), .addrUnit(addrUnit), .memAddr(memAddr),
    .memDataIn(memDataIn), .memDataOut(memDataOut)
  );

  typedef struct {
    logic [7:0] addr;
    logic [1:0] unit;
    logic       wr;
  } acc_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    time         t_acc;
  } exp_t;

  logic [7:0] mem [0:255];
  acc_t       log_q[$];
  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Memory: reads registered one edge after memRead, writes land on the strobe edge.
  always @(posedge clk) begin
    logic [7:0] a;
    a = memAddr;
    if (memRead)
      memDataOut <= {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    if (memWrite) begin
      mem[a] = memDataIn[7:0];
      if (addrUnit != 2'b00) mem[a + 8'd1] = memDataIn[15:8];
      if (addrUnit == 2'b10) begin
        mem[a + 8'd2] = memDataIn[23:16];
        mem[a + 8'd3] = memDataIn[31:24];
      end
    end
    if (memRead || memWrite) log_q.push_back('{a, addrUnit, memWrite});
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (memRead || memWrite) chk("strobe_exclusive", {31'd0, memRead && memWrite}, 32'd0);
      if (respValid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_resp actual=respValid expected=none data=0x%08h", respData);
        end else begin
          e = exp_q.pop_front();
          chk("resp_data", respData, e.data);
          chk("resp_err", {31'd0, respErr}, {31'd0, e.err});
          chk("latency", int'(($time - e.t_acc) / 10) - 1, e.lat);
        end
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (reqReady) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 expected=1");
    end
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout actual=pending%0d expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [7:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_data,
                        input logic exp_err, input int exp_lat);
    bit ok;
    log_q.delete();
    @(negedge clk);
    reqValid = 1'b1;
    reqWrite = wr;
    funct3   = f3;
    reqAddr  = addr;
    reqData  = data;
    wait_ready(ok);
    if (ok) begin
      exp_q.push_back('{exp_data, exp_err, exp_lat, $time});
      @(posedge clk);
      #1;
      // Scrambled inputs after accept must not leak into the transaction.
      reqValid = 1'b0;
      reqAddr  = ~addr;
      reqData  = ~data;
      funct3   = ~f3;
      wait_empty();
    end else begin
      reqValid = 1'b0;
    end
  endtask

  task automatic check_log(input string name, input int n, input logic [7:0] a0,
                           input logic [1:0] unit, input logic wr);
    logic [7:0] ea;
    chk({name, "_count"}, log_q.size(), n);
    for (int k = 0; k < n && k < log_q.size(); k++) begin
      ea = a0 + 8'(k);
      chk({name, "_addr"}, {24'd0, log_q[k].addr}, {24'd0, ea});
      chk({name, "_unit"}, {30'd0, log_q[k].unit}, {30'd0, unit});
      chk({name, "_wr"}, {31'd0, log_q[k].wr}, {31'd0, wr});
    end
  endtask

  initial begin
    bit  ok;
    time t0;
    time t1;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h80; mem[8'h11] = 8'h7F; mem[8'h12] = 8'h01; mem[8'h13] = 8'hFE;
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;

    #1;
    chk("rst_ready", {31'd0, reqReady}, 32'd1);
    chk("rst_resp_valid", {31'd0, respValid}, 32'd0);
    chk("rst_resp_err", {31'd0, respErr}, 32'd0);
    chk("rst_strobes", {30'd0, memRead, memWrite}, 32'd0);
    chk("rst_resp_data", respData, 32'd0);
    chk("rst_mem_addr", {24'd0, memAddr}, 32'd0);
    chk("rst_mem_din", memDataIn, 32'd0);
    chk("rst_unit", {30'd0, addrUnit}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_req(1'b0, 3'b000, 8'h10, 32'h0, 32'hFFFF_FF80, 1'b0, 2);
    check_log("lb10", 1, 8'h10, 2'b00, 1'b0);
    do_req(1'b0, 3'b101, 8'h11, 32'h0, 32'h0000_017F, 1'b0, 4);
    check_log("lhu11", 2, 8'h11, 2'b00, 1'b0);
    do_req(1'b0, 3'b001, 8'h12, 32'h0, 32'hFFFF_FE01, 1'b0, 2);
    check_log("lh12", 1, 8'h12, 2'b01, 1'b0);
    do_req(1'b1, 3'b010, 8'h13, 32'hDEAD_BEEF, 32'h0, 1'b0, 4);
    check_log("sw13", 4, 8'h13, 2'b00, 1'b1);
    chk("mem13", {24'd0, mem[8'h13]}, 32'hEF);
    chk("mem14", {24'd0, mem[8'h14]}, 32'hBE);
    chk("mem15", {24'd0, mem[8'h15]}, 32'hAD);
    chk("mem16", {24'd0, mem[8'h16]}, 32'hDE);
    do_req(1'b0, 3'b010, 8'h13, 32'h0, 32'hDEAD_BEEF, 1'b0, 8);
    check_log("lw13", 4, 8'h13, 2'b00, 1'b0);

    do_req(1'b0, 3'b011, 8'h10, 32'h0, 32'h0, 1'b1, 0);
    check_log("err_ld011", 0, 8'h00, 2'b00, 1'b0);
    do_req(1'b0, 3'b110, 8'h10, 32'h0, 32'h0, 1'b1, 0);
    check_log("err_ld110", 0, 8'h00, 2'b00, 1'b0);
    do_req(1'b1, 3'b011, 8'h40, 32'h1234_5678, 32'h0, 1'b1, 0);
    check_log("err_st011", 0, 8'h00, 2'b00, 1'b0);
    chk("err_st_nowrite", {24'd0, mem[8'h40]}, 32'h00);

    do_req(1'b1, 3'b000, 8'h30, 32'h1234_5678, 32'h0, 1'b0, 1);
    check_log("sb30", 1, 8'h30, 2'b00, 1'b1);
    do_req(1'b1, 3'b001, 8'h32, 32'hAABB_CCDD, 32'h0, 1'b0, 1);
    check_log("sh32", 1, 8'h32, 2'b01, 1'b1);
    do_req(1'b0, 3'b010, 8'h30, 32'h0, 32'hCCDD_0078, 1'b0, 2);
    check_log("lw30", 1, 8'h30, 2'b10, 1'b0);
    do_req(1'b0, 3'b100, 8'h33, 32'h0, 32'h0000_00CC, 1'b0, 2);
    do_req(1'b0, 3'b000, 8'h33, 32'h0, 32'hFFFF_FFCC, 1'b0, 2);

    do_req(1'b0, 3'b010, 8'hFE, 32'h0, 32'h4433_2211, 1'b0, 8);
    check_log("lw_wrap", 4, 8'hFE, 2'b00, 1'b0);
    do_req(1'b1, 3'b001, 8'h41, 32'h0000_BEEF, 32'h0, 1'b0, 2);
    check_log("sh41", 2, 8'h41, 2'b00, 1'b1);
    chk("mem41", {24'd0, mem[8'h41]}, 32'hEF);
    chk("mem42", {24'd0, mem[8'h42]}, 32'hBE);

    // A held reqValid is taken again right after the IDLE cycle that follows DONE.
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b0; funct3 = 3'b011; reqAddr = 8'h00;
    wait_ready(ok);
    if (ok) begin
      t0 = $time;
      exp_q.push_back('{32'h0, 1'b1, 0, t0});
      @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (reqReady) break;
      end
      t1 = $time;
      chk("held_gap", int'((t1 - t0) / 10), 2);
      exp_q.push_back('{32'h0, 1'b1, 0, t1});
      @(posedge clk);
      #1;
      reqValid = 1'b0;
      wait_empty();
    end else begin
      reqValid = 1'b0;
    end

    // Reset during the third beat of a split word store.
    log_q.delete();
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; funct3 = 3'b010; reqAddr = 8'h21; reqData = 32'h4433_2211;
    wait_ready(ok);
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("abort_beat2_we", {31'd0, memWrite}, 32'd1);
    chk("abort_beat2_addr", {24'd0, memAddr}, 32'h23);
    rst_n = 1'b0;
    #1;
    chk("abort_we_drop", {31'd0, memWrite}, 32'd0);
    chk("abort_ready", {31'd0, reqReady}, 32'd1);
    chk("abort_no_resp", {31'd0, respValid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_ready_after", {31'd0, reqReady}, 32'd1);
    chk("abort_mem21", {24'd0, mem[8'h21]}, 32'h11);
    chk("abort_mem22", {24'd0, mem[8'h22]}, 32'h22);
    chk("abort_mem23", {24'd0, mem[8'h23]}, 32'h00);
    chk("abort_mem24", {24'd0, mem[8'h24]}, 32'h00);

    do_req(1'b0, 3'b000, 8'h10, 32'h0, 32'hFFFF_FF80, 1'b0, 2);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
